// File: rtl/bsg_idiv_iterative_pkg.sv
// Shared state encoding and sizing helper for the iterative divider.
package bsg_idiv_iterative_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } idiv_state_e;

  function automatic int idiv_ctr_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bsg_idiv_iterative_controller.sv
// Divider sequencing: IDLE -> PREP -> CALC (width_p cycles) -> FIX -> DONE,
// plus the handshake outputs decoded from the state register.
module bsg_idiv_iterative_controller
  import bsg_idiv_iterative_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        v_i,
  input  logic        yumi_i,
  output logic        ready_o,
  output logic        v_o,
  output idiv_state_e state_o
);

  localparam int ctr_w_lp = idiv_ctr_width(width_p);
  localparam logic [ctr_w_lp-1:0] last_iter_lp = ctr_w_lp'(width_p - 1);

  idiv_state_e         state_q, state_d;
  logic [ctr_w_lp-1:0] ctr_q, ctr_d;

  // State and iteration counter registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      ctr_q   <= {ctr_w_lp{1'b0}};
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  // Next-state and counter logic; CALC runs for counter values 0..width_p-1
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      IDLE: begin
        if (v_i) state_d = PREP;
        else     state_d = IDLE;
      end
      PREP: begin
        state_d = CALC;
        ctr_d   = {ctr_w_lp{1'b0}};
      end
      CALC: begin
        if (ctr_q == last_iter_lp) begin
          state_d = FIX;
        end else begin
          ctr_d = ctr_q + ctr_w_lp'(32'd1);
        end
      end
      FIX:  state_d = DONE;
      DONE: begin
        if (yumi_i) state_d = IDLE;
        else        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    ready_o = 1'b0;
    v_o     = 1'b0;
    case (state_q)
      IDLE:    ready_o = 1'b1;
      DONE:    v_o     = 1'b1;
      default: begin
        ready_o = 1'b0;
        v_o     = 1'b0;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/bsg_idiv_iterative.sv
// Iterative signed/unsigned divider: one quotient bit per cycle via
// restoring shift-subtract on operand magnitudes, signs fixed up at the end.
module bsg_idiv_iterative
  import bsg_idiv_iterative_pkg::*;
#(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_div_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  output logic               v_o,
  input  logic               yumi_i
);

  idiv_state_e state_s;

  logic [width_p-1:0] dividend_q, dividend_d;
  logic [width_p-1:0] divisor_q, divisor_d;
  logic               signed_q, signed_d;
  logic [width_p-1:0] quot_q, quot_d;
  logic [width_p-1:0] rem_q, rem_d;
  logic [width_p-1:0] dmag_q, dmag_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dz_q, dz_d;
  logic [width_p-1:0] quotient_q, quotient_d;
  logic [width_p-1:0] remainder_q, remainder_d;

  logic               a_neg_s, b_neg_s;
  logic [width_p:0]   shifted_s;
  logic               borrow_s;
  logic [width_p-1:0] diff_s;

  bsg_idiv_iterative_controller #(
    .width_p (width_p)
  ) u_ctrl (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .yumi_i  (yumi_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .state_o (state_s)
  );

  // Datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dividend_q  <= {width_p{1'b0}};
      divisor_q   <= {width_p{1'b0}};
      signed_q    <= 1'b0;
      quot_q      <= {width_p{1'b0}};
      rem_q       <= {width_p{1'b0}};
      dmag_q      <= {width_p{1'b0}};
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      dz_q        <= 1'b0;
      quotient_q  <= {width_p{1'b0}};
      remainder_q <= {width_p{1'b0}};
    end else begin
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      signed_q    <= signed_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      dmag_q      <= dmag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  // The (width_p+1)-bit trial remainder never exceeds 2*divisor, so a
  // width_p-bit difference is exact whenever no borrow occurs.
  assign a_neg_s   = signed_q & dividend_q[width_p-1];
  assign b_neg_s   = signed_q & divisor_q[width_p-1];
  assign shifted_s = {rem_q, quot_q[width_p-1]};
  assign borrow_s  = (shifted_s < {1'b0, dmag_q});
  assign diff_s    = shifted_s[width_p-1:0] - dmag_q;

  // Datapath next-state per controller phase
  always_comb begin
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    signed_d    = signed_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    dmag_d      = dmag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_s)
      IDLE: begin
        dividend_d = v_i ? dividend_i   : dividend_q;
        divisor_d  = v_i ? divisor_i    : divisor_q;
        signed_d   = v_i ? signed_div_i : signed_q;
      end
      PREP: begin
        quot_d  = a_neg_s ? -dividend_q : dividend_q;
        dmag_d  = b_neg_s ? -divisor_q  : divisor_q;
        rem_d   = {width_p{1'b0}};
        q_neg_d = a_neg_s ^ b_neg_s;
        r_neg_d = a_neg_s;
        dz_d    = (divisor_q == {width_p{1'b0}});
      end
      CALC: begin
        if (borrow_s) begin
          rem_d  = shifted_s[width_p-1:0];
          quot_d = {quot_q[width_p-2:0], 1'b0};
        end else begin
          rem_d  = diff_s;
          quot_d = {quot_q[width_p-2:0], 1'b1};
        end
      end
      FIX: begin
        // Divide-by-zero keeps the all-ones quotient regardless of sign.
        quotient_d  = (q_neg_q & ~dz_q) ? -quot_q : quot_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
      end
      DONE: begin
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
      end
      default: begin
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
      end
    endcase
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_bsg_idiv_iterative.sv
// Scoreboard bench for bsg_idiv_iterative at width_p=32 (directed, handshake,
// reset abort) and width_p=64 (randomized against an arithmetic reference).
module tb_bsg_idiv_iterative;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          acc;
  } exp_t;

  logic clk;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  logic        reset_i  [2];
  logic        v_i      [2];
  logic        signed_i [2];
  logic        yumi_i   [2];
  logic [63:0] a_i      [2];
  logic [63:0] b_i      [2];
  logic        ready_o  [2];
  logic        v_o      [2];
  logic [63:0] q_o      [2];
  logic [63:0] r_o      [2];

  logic        rdy32, v32, rdy64, v64;
  logic [31:0] q32, r32;
  logic [63:0] q64, r64;

  exp_t sb [2][$];
  int   force_hold [2];
  int   wid [2];

  bsg_idiv_iterative #(.width_p(32)) dut32 (
    .clk_i        (clk),
    .reset_i      (reset_i[0]),
    .v_i          (v_i[0]),
    .ready_o      (rdy32),
    .dividend_i   (a_i[0][31:0]),
    .divisor_i    (b_i[0][31:0]),
    .signed_div_i (signed_i[0]),
    .quotient_o   (q32),
    .remainder_o  (r32),
    .v_o          (v32),
    .yumi_i       (yumi_i[0])
  );

  bsg_idiv_iterative #(.width_p(64)) dut64 (
    .clk_i        (clk),
    .reset_i      (reset_i[1]),
    .v_i          (v_i[1]),
    .ready_o      (rdy64),
    .dividend_i   (a_i[1]),
    .divisor_i    (b_i[1]),
    .signed_div_i (signed_i[1]),
    .quotient_o   (q64),
    .remainder_o  (r64),
    .v_o          (v64),
    .yumi_i       (yumi_i[1])
  );

  assign ready_o[0] = rdy32;
  assign v_o[0]     = v32;
  assign q_o[0]     = {32'h0, q32};
  assign r_o[0]     = {32'h0, r32};
  assign ready_o[1] = rdy64;
  assign v_o[1]     = v64;
  assign q_o[1]     = q64;
  assign r_o[1]     = r64;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d actual=%h expected=%h (t=%0t)", name, k, act, exp, $time);
  endtask

  function automatic logic [63:0] mask_of(input int w);
    logic [63:0] m;
    m = '1;
    return m >> (64 - w);
  endfunction

  // Reference: C semantics via 64-bit signed / and %, zero divisor per rule.
  function automatic void ref_div(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                  input logic sgn, output logic [63:0] q, output logic [63:0] r);
    logic [63:0] m, a, b;
    longint sa, sb;
    m = mask_of(w);
    a = a_in & m;
    b = b_in & m;
    if (b == 64'd0) begin
      q = m;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = longint'(a << (64 - w));
      sa = sa >>> (64 - w);
      sb = longint'(b << (64 - w));
      sb = sb >>> (64 - w);
      if (sb == -64'sd1) begin
        q = 64'(-sa);
        r = 64'd0;
      end else begin
        q = 64'(sa / sb);
        r = 64'(sa % sb);
      end
    end
    q = q & m;
    r = r & m;
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] v;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0: v = 64'd0;
      1: v = 64'd1;
      2: v = '1;
      3: v = 64'd1 << (w - 1);
      4: v = v >> $urandom_range(40, 63);
      5: v = -(v >> $urandom_range(40, 63));
      default: v = v;
    endcase
    return v & mask_of(w);
  endfunction

  task automatic issue(input int k, input logic [63:0] a, input logic [63:0] b, input logic sgn,
                       input logic [63:0] eq, input logic [63:0] er, input bit hold_v, input bit expect_it);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!ready_o[k] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o[k]) begin
      chk("ready_timeout", k, 64'(ready_o[k]), 64'd1);
      return;
    end
    v_i[k] = 1'b1;
    a_i[k] = a;
    b_i[k] = b;
    signed_i[k] = sgn;
    @(posedge clk);
    #1;
    if (expect_it) begin
      e.q = eq;
      e.r = er;
      e.acc = cyc;
      sb[k].push_back(e);
    end
    @(negedge clk);
    chk("ready_drop", k, 64'(ready_o[k]), 64'd0);
    if (hold_v) begin
      a_i[k] = {$urandom, $urandom};
      b_i[k] = {$urandom, $urandom};
      signed_i[k] = ~sgn;
      n = 0;
      while (!v_o[k] && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    v_i[k] = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each new result and consumes it with yumi
  initial begin : monitor
    bit   prev_v [2];
    int   hold [2];
    exp_t cur [2];
    for (int k = 0; k < 2; k++) begin
      prev_v[k] = 1'b0;
      hold[k] = 0;
      yumi_i[k] = 1'b0;
      cur[k] = '{q: 64'd0, r: 64'd0, acc: 0};
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset_i[k]) begin
          prev_v[k] = 1'b0;
          yumi_i[k] = 1'b0;
        end else if (yumi_i[k]) begin
          chk("v_drop_after_yumi", k, 64'(v_o[k]), 64'd0);
          chk("ready_after_yumi", k, 64'(ready_o[k]), 64'd1);
          yumi_i[k] = 1'b0;
          prev_v[k] = 1'b0;
        end else if (v_o[k]) begin
          if (!prev_v[k]) begin
            if (sb[k].size() == 0) begin
              chk("unexpected_result", k, 64'(sb[k].size() + 1), 64'd0);
              cur[k] = '{q: q_o[k], r: r_o[k], acc: cyc - wid[k] - 2};
            end else begin
              cur[k] = sb[k].pop_front();
              chk("latency", k, 64'(cyc - cur[k].acc), 64'(wid[k] + 2));
            end
            hold[k] = (force_hold[k] >= 0) ? force_hold[k] : $urandom_range(0, 3);
          end
          chk("quotient", k, q_o[k], cur[k].q);
          chk("remainder", k, r_o[k], cur[k].r);
          chk("v_and_ready", k, 64'(ready_o[k]), 64'd0);
          if (hold[k] == 0) yumi_i[k] = 1'b1;
          else hold[k] = hold[k] - 1;
          prev_v[k] = 1'b1;
        end else begin
          prev_v[k] = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    logic [63:0] a, b, eq, er;
    logic s;
    bit seen_v;
    int n;
    wid[0] = 32;
    wid[1] = 64;
    for (int k = 0; k < 2; k++) begin
      reset_i[k] = 1'b1;
      v_i[k] = 1'b0;
      signed_i[k] = 1'b0;
      a_i[k] = 64'd0;
      b_i[k] = 64'd0;
      force_hold[k] = -1;
    end
    repeat (3) @(negedge clk);
    reset_i[0] = 1'b0;
    reset_i[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_ready", k, 64'(ready_o[k]), 64'd1);
      chk("reset_v", k, 64'(v_o[k]), 64'd0);
      chk("reset_q", k, q_o[k], 64'd0);
      chk("reset_r", k, r_o[k], 64'd0);
    end

    // Directed 32-bit cases with hand-derived results
    issue(0, 64'd100,        64'd7,        1'b0, 64'd14,         64'd2,        0, 1);
    issue(0, 64'hFFFFFFF9,   64'd2,        1'b1, 64'hFFFFFFFD,   64'hFFFFFFFF, 0, 1);
    issue(0, 64'd7,          64'hFFFFFFFE, 1'b1, 64'hFFFFFFFD,   64'd1,        0, 1);
    issue(0, 64'hFFFFFFF9,   64'hFFFFFFFE, 1'b1, 64'd3,          64'hFFFFFFFF, 0, 1);
    issue(0, 64'hFFFFFFFF,   64'd2,        1'b0, 64'h7FFFFFFF,   64'd1,        0, 1);
    issue(0, 64'hFFFFFFFF,   64'd2,        1'b1, 64'd0,          64'hFFFFFFFF, 0, 1);
    issue(0, 64'h1234,       64'd0,        1'b0, 64'hFFFFFFFF,   64'h1234,     0, 1);
    issue(0, 64'hFFFFFFF9,   64'd0,        1'b1, 64'hFFFFFFFF,   64'hFFFFFFF9, 0, 1);
    issue(0, 64'h80000000,   64'hFFFFFFFF, 1'b1, 64'h80000000,   64'd0,        0, 1);
    issue(0, 64'h80000000,   64'hFFFFFFFF, 1'b0, 64'd0,          64'h80000000, 0, 1);
    issue(0, 64'h80000000,   64'd1,        1'b1, 64'h80000000,   64'd0,        0, 1);
    issue(0, 64'h80000000,   64'd2,        1'b1, 64'hC0000000,   64'd0,        0, 1);
    issue(0, 64'd0,          64'd5,        1'b1, 64'd0,          64'd0,        0, 1);

    // Handshake: v_i held and inputs scrambled mid-op, yumi delayed 5 cycles
    force_hold[0] = 5;
    issue(0, 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1, 1);
    issue(0, 64'hFFFFFFF9, 64'd2, 1'b1, 64'hFFFFFFFD, 64'hFFFFFFFF, 1, 1);
    force_hold[0] = -1;

    // Reset during CALC aborts the division with no result
    issue(0, 64'h12345678, 64'd3, 1'b0, 64'd0, 64'd0, 0, 0);
    repeat (8) @(negedge clk);
    reset_i[0] = 1'b1;
    @(negedge clk);
    reset_i[0] = 1'b0;
    chk("abort_ready", 0, 64'(ready_o[0]), 64'd1);
    seen_v = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_v = seen_v | v_o[0];
    end
    chk("abort_no_v", 0, 64'(seen_v), 64'd0);
    issue(0, 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 0, 1);

    // 64-bit boundary cases, then random signed and unsigned regressions
    issue(1, 64'h8000000000000000, '1, 1'b1, 64'h8000000000000000, 64'd0, 0, 1);
    issue(1, 64'h8000000000000000, '1, 1'b0, 64'd0, 64'h8000000000000000, 0, 1);
    issue(1, 64'hFFFFFFFFFFFFFFF9, 64'd0, 1'b1, '1, 64'hFFFFFFFFFFFFFFF9, 0, 1);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 300; i++) begin
        a = rnd_op(64);
        b = rnd_op(64);
        s = (m == 0);
        ref_div(64, a, b, s, eq, er);
        issue(1, a, b, s, eq, er, 0, 1);
      end
    end
    for (int i = 0; i < 100; i++) begin
      a = rnd_op(32);
      b = rnd_op(32);
      s = 1'($urandom_range(0, 1));
      ref_div(32, a, b, s, eq, er);
      issue(0, a, b, s, eq, er, 0, 1);
    end

    n = 0;
    while ((sb[0].size() != 0 || sb[1].size() != 0 || v_o[0] || v_o[1]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 0, 64'(sb[0].size() + sb[1].size()), 64'd0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
